mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between instruction fetch and the load/store path. It arbitrates fairly when both request, and sequences one outstanding transaction through a request/grant/response protocol. On the data side it generates byte enables and store-data lanes from the decoded `mem_size`, and sign/zero-extends load data from `mem_unsigned`. Misaligned or illegal accesses are rejected locally with an error response and never reach memory.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted (1-cycle pulse).
- `if_rvalid` out 1: fetch response valid (1-cycle pulse).
- `if_rdata` out 32: instruction word.
- `if_err` out 1: qualifies `if_rvalid`; misaligned fetch.
- `d_req` in 1: data request; held with fields stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `d_unsigned` in 1: zero-extend load result.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_gnt` out 1: data request accepted (1-cycle pulse).
- `d_rvalid` out 1: data response valid (1-cycle pulse), for loads and stores.
- `d_rdata` out 32: extended load data; 0 for stores and errors.
- `d_err` out 1: qualifies `d_rvalid`.
- `mem_req` out 1: memory request; held until `mem_gnt`.
- `mem_we` out 1: write strobe.
- `mem_be` out 4: byte enables.
- `mem_addr` out 32: word-aligned address (`[1:0]` = 0).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: memory accepted request.
- `mem_rvalid` in 1: memory response; arrives at least 1 cycle after `mem_gnt`.
- `mem_rdata` in 32: read word.

## Operation
- FSM states:
  - IDLE: may accept a request.
  - REQ: `mem_req` driven, waiting for `mem_gnt`.
  - RESP: waiting for `mem_rvalid`.
  - ERR: emits a local error response.
- IDLE selection:
  - Only one requester active: it is granted.
  - Both active: the requester not granted last is granted. `last_grant` resets to fetch, so data wins the first tie.
  - `x_gnt` is combinational in IDLE. Address, size, we, unsigned, wdata and owner are latched on the same edge.
- Alignment check at grant. Legal accesses go to REQ; illegal ones go to ERR:
  - Fetch illegal if `if_addr[1:0]` ≠ 0.
  - Data illegal if `d_size` = 3, or half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
- Memory outputs in REQ (registered from latched fields):
  - Fetch: `mem_we` = 0, `mem_be` = 4'b1111.
  - Byte: `mem_be` = 4'b0001 << off, `mem_wdata` = {4{wdata[7:0]}}.
  - Half: `mem_be` = 4'b0011 << off, `mem_wdata` = {2{wdata[15:0]}}.
  - Word: `mem_be` = 4'b1111, `mem_wdata` = wdata.
  - `off` = `addr[1:0]`.
- REQ → RESP on `mem_gnt`.
- RESP → IDLE on `mem_rvalid`. The owner's `x_rvalid` pulses combinationally in that cycle with `x_err` = 0.
  - Fetch: `if_rdata` = `mem_rdata`.
  - Load: select lane `off`, then sign-extend, or zero-extend if `d_unsigned`.
  - Store: `d_rdata` = 0.
- ERR → IDLE unconditionally. The owner's `x_rvalid` and `x_err` pulse for 1 cycle; rdata = 0. No `mem_req` is issued.
- `mem_rvalid` / `mem_gnt` in IDLE or ERR are ignored; `mem_rvalid` in REQ is ignored.
- Non-IDLE states never assert any `x_gnt`. Requests wait.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `last_grant` = fetch; all outputs 0 (`mem_addr`, `mem_wdata`, `mem_be` = 0).
- Reset mid-transaction aborts it. No response is delivered, and the memory is reset with the core.
- Best-case legal access:
  - Cycle 0: req and `x_gnt`.
  - Cycle 1: `mem_req` with `mem_gnt`.
  - Cycle 2: `mem_rvalid` and `x_rvalid`.
  - Cycle 3: next grant possible (IDLE).
- Error access: grant at cycle 0, `x_rvalid`/`x_err` at cycle 1, IDLE at cycle 2.
- `mem_req` and its fields stay stable from REQ entry until `mem_gnt`, inclusive.
- Throughput: at most one outstanding transaction; minimum 3 cycles per legal access.

## Test plan
- Fetch only: `if_addr` = 0x100, `mem_gnt` at cycle 1, `mem_rvalid` at cycle 2 with 0x00000013 → `if_gnt` @0, `mem_req`/`mem_be` = 1111/`mem_addr` = 0x100 @1, `if_rvalid` with 0x13 @2, `if_err` = 0.
- Simultaneous requests after reset, held for 3 transactions → grant order data, fetch, data; `mem_req` never asserts in IDLE.
- Signed byte load at 0x203, `mem_rdata` = 0x80_00_00_00 → `mem_be` = 1000, `d_rdata` = 0xFFFFFF80. With `d_unsigned` = 1 → 0x00000080. Half at 0x202 with `mem_rdata` = 0x8001_xxxx, signed → 0xFFFF8001.
- Half store 0xABCD at 0x302 → `mem_we` = 1, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `mem_addr` = 0x300; `d_rvalid` with `d_rdata` = 0.
- Misaligned word load at 0x401, and `d_size` = 3 → `d_rvalid` and `d_err` one cycle after `d_gnt`, `d_rdata` = 0, `mem_req` stays 0. Fetch at 0x102 → `if_err`.
- `mem_gnt` delayed 4 cycles, then `rst_n` low during RESP → `mem_req`/fields stable while waiting; on reset all outputs drop to 0 immediately; the late `mem_rvalid` is ignored; the next tie grants data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store, one outstanding transaction.
// Data side does lane steering, byte enables, load extension and local alignment rejection.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | may accept a request
  // REQ   | mem_req driven, waiting for mem_gnt
  // RESP  | waiting for mem_rvalid
  // ERR   | emits a local error response
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t      state_q, state_d;
  logic        own_q;       // 1 = data owns the transaction
  logic        last_q;      // 1 = data was granted last
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        sel_data;
  logic        grant;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        rsp_ok;
  logic        rsp_err;
  logic [31:0] lane;
  logic [31:0] ext;

  always_comb begin
    sel_data = d_req && (!if_req || !last_q);
    grant    = (state_q == IDLE) && (if_req || d_req);
    if_gnt   = grant && !sel_data;
    d_gnt    = grant && sel_data;

    illegal = 1'b0;
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (sel_data) begin
      case (d_size)
        2'd0: begin
          be_d    = 4'b0001 << d_addr[1:0];
          wdata_d = {4{d_wdata[7:0]}};
        end
        2'd1: begin
          illegal = d_addr[0];
          be_d    = 4'b0011 << d_addr[1:0];
          wdata_d = {2{d_wdata[15:0]}};
        end
        2'd2: begin
          illegal = (d_addr[1:0] != 2'b00);
          wdata_d = d_wdata;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      illegal = (if_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = illegal ? ERR : REQ;
      REQ:  if (mem_gnt) state_d = RESP;
      RESP: if (mem_rvalid) state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      own_q     <= 1'b0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        own_q  <= sel_data;
        last_q <= sel_data;
        we_q   <= sel_data && d_we;
        uns_q  <= d_unsigned;
        size_q <= sel_data ? d_size : 2'd2;
        off_q  <= sel_data ? d_addr[1:0] : if_addr[1:0];
        if (!illegal) begin
          mem_req   <= 1'b1;
          mem_we    <= sel_data && d_we;
          mem_be    <= be_d;
          mem_addr  <= sel_data ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
          mem_wdata <= (sel_data && d_we) ? wdata_d : 32'h0;
        end
      end else if (state_q == REQ && mem_gnt) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_be    <= 4'b0000;
        mem_addr  <= 32'h0;
        mem_wdata <= 32'h0;
      end
    end
  end

  // Load extension: bring the addressed lane down to bit 0 first.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ext = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1:    ext = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    rsp_ok    = (state_q == RESP) && mem_rvalid;
    rsp_err   = (state_q == ERR);
    if_rvalid = (rsp_ok || rsp_err) && !own_q;
    if_err    = rsp_err && !own_q;
    if_rdata  = (rsp_ok && !own_q) ? mem_rdata : 32'h0;
    d_rvalid  = (rsp_ok || rsp_err) && own_q;
    d_err     = rsp_err && own_q;
    d_rdata   = (rsp_ok && own_q && !we_q) ? ext : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus
// tie-break, stall and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic        chk_wd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0;
    d_addr = 0; d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", i);
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    @(negedge clk);
    check({tag, " gnt"}, {30'h0, d_gnt, if_gnt}, v.is_d ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    if (v.exp_err) begin
      @(negedge clk);
      check({tag, " err rsp"}, {28'h0, d_rvalid, d_err, if_rvalid, if_err},
            v.is_d ? 32'hC : 32'h3);
      check({tag, " err rdata"}, v.is_d ? d_rdata : if_rdata, 32'h0);
      check({tag, " err no mem_req"}, {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
    end else begin
      mem_gnt = 1;
      @(negedge clk);
      check({tag, " mem_req"}, {31'h0, mem_req}, 32'h1);
      check({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
      check({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, v.exp_be});
      check({tag, " mem_addr"}, mem_addr, v.exp_addr);
      if (v.chk_wd) check({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
      check({tag, " no early rvalid"}, {30'h0, d_rvalid, if_rvalid}, 32'h0);
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = v.rdata;
      @(negedge clk);
      check({tag, " rvalid"}, {28'h0, d_rvalid, d_err, if_rvalid, if_err},
            v.is_d ? 32'h8 : 32'h2);
      check({tag, " rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
      check({tag, " other rdata"}, v.is_d ? if_rdata : d_rdata, 32'h0);
      @(posedge clk); #1;
      mem_rvalid = 0; mem_rdata = 0;
    end
  endtask

  initial begin
    //          is_d we sz uns addr          wdata         rdata         err be       addr          chkwd wdata         rdata
    vecs[0]  = '{1'b0, 0, 2, 0, 32'h100, 32'h0,        32'h00000013, 0, 4'b1111, 32'h100, 0, 32'h0,        32'h00000013};
    vecs[1]  = '{1'b1, 0, 0, 0, 32'h203, 32'h0,        32'h80000000, 0, 4'b1000, 32'h200, 0, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 0, 0, 1, 32'h203, 32'h0,        32'h80000000, 0, 4'b1000, 32'h200, 0, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 0, 1, 0, 32'h202, 32'h0,        32'h80011234, 0, 4'b1100, 32'h200, 0, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{1'b1, 1, 1, 0, 32'h302, 32'h0000ABCD, 32'hDEADBEEF, 0, 4'b1100, 32'h300, 1, 32'hABCDABCD, 32'h0};
    vecs[5]  = '{1'b1, 0, 2, 0, 32'h401, 32'h0,        32'h0,        1, 4'b0000, 32'h0,   0, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 0, 3, 0, 32'h400, 32'h0,        32'h0,        1, 4'b0000, 32'h0,   0, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 0, 2, 0, 32'h102, 32'h0,        32'h0,        1, 4'b0000, 32'h0,   0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1, 0, 0, 32'h301, 32'h1234565A, 32'hFFFFFFFF, 0, 4'b0010, 32'h300, 1, 32'h5A5A5A5A, 32'h0};
    vecs[9]  = '{1'b1, 0, 2, 0, 32'h404, 32'h0,        32'h12345678, 0, 4'b1111, 32'h404, 0, 32'h0,        32'h12345678};
    vecs[10] = '{1'b1, 0, 1, 1, 32'h200, 32'h0,        32'h0000F00D, 0, 4'b0011, 32'h200, 0, 32'h0,        32'h0000F00D};
    vecs[11] = '{1'b1, 0, 0, 0, 32'h201, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h200, 0, 32'h0,        32'h0000007F};

    idle_inputs();
    rst_n = 0;
    #1;
    check("reset outputs", {mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err},
          32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Both requesters held for three back-to-back legal transactions.
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 0; d_size = 2; d_addr = 32'h40;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("tie%0d gnt", t), {30'h0, d_gnt, if_gnt}, (t == 1) ? 32'd1 : 32'd2);
      check($sformatf("tie%0d idle mem_req", t), {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      mem_gnt = 1;
      @(negedge clk);
      check($sformatf("tie%0d mem_addr", t), mem_addr, (t == 1) ? 32'h80 : 32'h40);
      check($sformatf("tie%0d no gnt in REQ", t), {30'h0, d_gnt, if_gnt}, 32'h0);
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hC0DE0000 + t;
      @(negedge clk);
      check($sformatf("tie%0d owner rvalid", t), {30'h0, d_rvalid, if_rvalid},
            (t == 1) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      mem_rvalid = 0;
    end
    idle_inputs();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Stalled grant, then reset while waiting for the response.
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_size = 2; d_addr = 32'h500; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    d_req = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d mem_req", c), {31'h0, mem_req, mem_we, mem_be}, 32'h3F);
      check($sformatf("stall%0d mem_addr", c), mem_addr, 32'h500);
      check($sformatf("stall%0d mem_wdata", c), mem_wdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    mem_gnt = 1;
    @(negedge clk);
    check("stall gnt cycle mem_req", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    mem_gnt = 0;
    #2 rst_n = 0;
    #1;
    check("abort outputs", {mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err},
          32'h0);
    check("abort mem_addr", mem_addr, 32'h0);
    check("abort mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h11111111;
    @(negedge clk);
    check("late rvalid ignored", {30'h0, d_rvalid, if_rvalid}, 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    if_req = 1; if_addr = 32'h0; d_req = 1; d_size = 2; d_we = 0; d_addr = 32'h8;
    @(negedge clk);
    check("post-reset tie gnt", {30'h0, d_gnt, if_gnt}, 32'd2);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
